// File: rtl/hkspi_responder.sv
// Housekeeping SPI responder: oversamples the SPI pins and turns the
// command/address/data byte stream into register-file strobes.
module hkspi_responder (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       spi_csb,
    input  logic       spi_sck,
    input  logic       spi_sdi,
    output logic       spi_sdo,
    output logic       spi_sdo_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wstb,
    output logic       reg_rstb,
    input  logic [7:0] reg_rdata,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, COMMAND, ADDRESS, DATA, DONE} state_t;
    state_t state, state_next;

    logic [2:0] csb_q, sck_q;
    logic [1:0] sdi_q;
    logic       csb_s, csb_d, sck_s, sck_d, sdi_s;
    logic       rise, fall;
    logic [7:0] shift_reg, out_sr;
    logic [2:0] bit_cnt, byte_cnt, n_bytes;
    logic [1:0] op;
    logic       byte_done, take, adv, rstb_d, sdo_q, last_byte, shift_out;

    assign csb_s = csb_q[1];
    assign csb_d = csb_q[2];
    assign sck_s = sck_q[1];
    assign sck_d = sck_q[2];
    assign sdi_s = sdi_q[1];
    assign rise  = sck_s & ~sck_d;
    assign fall  = ~sck_s & sck_d;

    // A CSB abort in the same cycle as a completed byte suppresses it
    assign take      = byte_done & ~csb_s;
    assign last_byte = (n_bytes != 3'd0) && (byte_cnt + 3'd1 == n_bytes);
    assign shift_out = fall && (state == DATA);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            csb_q <= '0;
            sck_q <= '0;
            sdi_q <= '0;
        end else begin
            csb_q <= {csb_q[1:0], spi_csb};
            sck_q <= {sck_q[1:0], spi_sck};
            sdi_q <= {sdi_q[0], spi_sdi};
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (csb_s) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (csb_d) state_next = COMMAND;
                COMMAND: if (byte_done)
                    state_next = (shift_reg[7:6] == 2'b00) ? DONE : ADDRESS;
                ADDRESS: if (byte_done) state_next = DATA;
                DATA:    if (byte_done && last_byte) state_next = DONE;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || csb_s || state == IDLE) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (rise && state != DONE) begin
                shift_reg <= {shift_reg[6:0], sdi_s};
                bit_cnt   <= bit_cnt + 3'd1;
                byte_done <= (bit_cnt == 3'd7);
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wstb  <= 1'b0;
            reg_rstb  <= 1'b0;
            op        <= '0;
            n_bytes   <= '0;
            byte_cnt  <= '0;
            adv       <= 1'b0;
            rstb_d    <= 1'b0;
        end else begin
            reg_wstb <= 1'b0;
            reg_rstb <= 1'b0;
            adv      <= 1'b0;
            rstb_d   <= reg_rstb;
            if (take) begin
                case (state)
                    COMMAND: begin
                        op      <= shift_reg[7:6];
                        n_bytes <= shift_reg[5:3];
                    end
                    ADDRESS: begin
                        reg_addr <= shift_reg;
                        reg_rstb <= op[0];
                    end
                    DATA: begin
                        byte_cnt <= byte_cnt + 3'd1;
                        reg_wstb <= op[1];
                        if (op[1]) reg_wdata <= shift_reg;
                        adv      <= 1'b1;
                    end
                    default: ;
                endcase
            end
            // Address advances one cycle after the write so wstb sees the old one
            if (adv) begin
                reg_addr <= reg_addr + 8'd1;
                reg_rstb <= op[0] && (state == DATA) && !csb_s;
            end
            if (csb_s || state == IDLE) byte_cnt <= '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || csb_s) begin
            out_sr <= '0;
            sdo_q  <= 1'b0;
        end else if (rstb_d && shift_out) begin
            sdo_q  <= reg_rdata[7];
            out_sr <= {reg_rdata[6:0], 1'b0};
        end else if (rstb_d) begin
            out_sr <= reg_rdata;
        end else if (shift_out) begin
            sdo_q  <= out_sr[7];
            out_sr <= {out_sr[6:0], 1'b0};
        end
    end

    assign spi_sdo_oe = (state == DATA) && op[0];
    assign spi_sdo    = spi_sdo_oe & sdo_q;
    assign busy       = ~csb_s && (state != IDLE);

endmodule

// File: tb/tb_hkspi_responder.sv
// Bench for hkspi_responder: directed and random SPI transactions compared
// against a transaction-level model of the register protocol.
module tb_hkspi_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic csb = 1'b1;
    logic sck = 1'b0;
    logic sdi = 1'b0;
    logic sdo, sdo_oe, wstb, rstb, busy;
    logic [7:0] addr, wdata, rdata;

    always #5 clk = ~clk;

    hkspi_responder dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .spi_csb   (csb),
        .spi_sck   (sck),
        .spi_sdi   (sdi),
        .spi_sdo   (sdo),
        .spi_sdo_oe(sdo_oe),
        .reg_addr  (addr),
        .reg_wdata (wdata),
        .reg_wstb  (wstb),
        .reg_rstb  (rstb),
        .reg_rdata (rdata),
        .busy      (busy)
    );

    logic [7:0] regs [256];
    logic [7:0] model_mem [256];

    // Register bank: read data returned the cycle after the strobe
    always @(posedge clk) begin
        if (wstb) regs[addr] = wdata;
        if (rstb) rdata <= regs[addr];
    end

    int cyc = 0;
    int last_rise = 0;
    int oe_cnt = 0;
    int sdo_bad = 0;
    logic [15:0] wq[$];
    logic [7:0]  rq[$];
    int          lat_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wstb) begin
            wq.push_back({addr, wdata});
            lat_q.push_back(cyc - last_rise);
        end
        if (rstb) rq.push_back(addr);
        if (sdo_oe) oe_cnt = oe_cnt + 1;
        if (!sdo_oe && sdo) sdo_bad = sdo_bad + 1;
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_sdo"}, sdo, 0);
        check({tag, "_oe"}, sdo_oe, 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_wdata"}, wdata, 0);
        check({tag, "_wstb"}, wstb, 0);
        check({tag, "_rstb"}, rstb, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            sdi = tx[7-i];
            repeat ($urandom_range(6, 4)) @(negedge clk);
            rx = {rx[6:0], sdo};
            sck = 1'b1;
            last_rise = cyc;
            repeat ($urandom_range(6, 4)) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    logic [7:0] tx_q[$];

    task automatic xfer(input int partial);
        logic [7:0]  rx[$];
        logic [15:0] ew[$];
        logic [7:0]  er[$];
        logic [7:0]  erx[$];
        logic [7:0]  r, a;
        logic [1:0]  op;
        logic [2:0]  n;
        int w0, r0, o0, k, eff;
        bit exp_oe_end;
        op = tx_q[0][7:6];
        n  = tx_q[0][5:3];
        exp_oe_end = 1'b0;
        if (tx_q.size() >= 2 && op != 2'b00) begin
            a   = tx_q[1];
            k   = tx_q.size() - 2;
            eff = (n == 0 || k < int'(n)) ? k : int'(n);
            exp_oe_end = op[0] && (n == 0 || k < int'(n));
            if (op[0]) er.push_back(a);
            for (int i = 0; i < eff; i++) begin
                if (op[0]) erx.push_back(model_mem[a]);
                if (op[1]) begin
                    ew.push_back({a, tx_q[2+i]});
                    model_mem[a] = tx_q[2+i];
                end
                a = a + 8'd1;
                if (op[0] && (n == 0 || i + 1 < int'(n))) er.push_back(a);
            end
        end
        w0 = wq.size();
        r0 = rq.size();
        o0 = oe_cnt;
        csb = 1'b0;
        foreach (tx_q[i]) begin
            spi_bits(tx_q[i], 8, r);
            rx.push_back(r);
        end
        if (partial > 0) spi_bits(8'($urandom), partial, r);
        repeat (4) @(negedge clk);
        check("busy_low", busy, 1);
        check("oe_end", sdo_oe, exp_oe_end);
        csb = 1'b1;
        repeat (8) @(negedge clk);
        check("busy_idle", busy, 0);
        check("n_writes", wq.size() - w0, ew.size());
        foreach (ew[i]) check("write", wq[w0+i], ew[i]);
        check("n_reads", rq.size() - r0, er.size());
        foreach (er[i]) check("read_addr", rq[r0+i], er[i]);
        foreach (erx[i]) check("sdo_byte", rx[2+i], erx[i]);
        check("oe_seen", oe_cnt != o0, op[0] && tx_q.size() >= 2);
    endtask

    initial begin
        logic [7:0] v, r;
        int w0, r0, sz, part;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            regs[i] = v;
            model_mem[i] = v;
        end
        regs[8'h05] = 8'hA5; model_mem[8'h05] = 8'hA5;
        regs[8'h10] = 8'h3C; model_mem[8'h10] = 8'h3C;
        regs[8'h11] = 8'h5A; model_mem[8'h11] = 8'h5A;

        repeat (4) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        tx_q = '{8'h80, 8'h13, 8'h66};
        xfer(0);
        check("wstb_latency", lat_q[$], 4);

        tx_q = '{8'h80, 8'hFE, 8'h11, 8'h22, 8'h33};
        xfer(0);

        tx_q = '{8'h48, 8'h05, 8'hFF, 8'hFF};
        xfer(0);

        tx_q = '{8'hC0, 8'h10, 8'hAA};
        xfer(0);

        tx_q = '{8'h00, 8'h12, 8'h34};
        xfer(0);

        tx_q = '{8'h80, 8'h30};
        xfer(5);
        tx_q = '{8'h80, 8'h31, 8'h55};
        xfer(0);

        // Reset in the middle of the address byte, then keep clocking
        w0 = wq.size();
        r0 = rq.size();
        csb = 1'b0;
        spi_bits(8'h80, 8, r);
        spi_bits(8'h2C, 4, r);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset("midrst");
        rst = 1'b0;
        spi_bits(8'hC0, 4, r);
        spi_bits(8'h77, 8, r);
        repeat (4) @(negedge clk);
        check("midrst_busy", busy, 0);
        csb = 1'b1;
        repeat (8) @(negedge clk);
        check("midrst_writes", wq.size() - w0, 0);
        check("midrst_reads", rq.size() - r0, 0);
        tx_q = '{8'hD0, 8'h2C, 8'h99, 8'h98};
        xfer(0);

        for (int t = 0; t < 24; t++) begin
            tx_q.delete();
            sz = $urandom_range(6, 1);
            for (int b = 0; b < sz; b++) tx_q.push_back(8'($urandom));
            part = ($urandom_range(3, 0) == 0) ? $urandom_range(7, 1) : 0;
            xfer(part);
        end

        check("sdo_quiet", sdo_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
